// File: rtl/mem_byte_unit.sv
// rtl/mem_byte_unit.sv - LC-3b LDB/LDW/STB/STW memory-access stage with byte lanes and ready timeout
module mem_byte_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        unaligned,
    output logic        timeout,
    output logic [15:0] rdata,
    output logic [7:0]  rbyte,
    output logic        mem_en,
    output logic [1:0]  mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_r
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_FAULT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we_l;
    logic        r_lsb_l;
    logic        r_busy;
    logic        r_done;
    logic        r_unaligned;
    logic        r_timeout;
    logic [15:0] r_rdata;
    logic [7:0]  r_rbyte;
    logic        r_mem_en;
    logic [1:0]  r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;

    logic [1:0]  w_mem_we;
    logic [15:0] w_mem_wdata;
    logic        w_misaligned;

    // Lane enables and replicated store byte are formed from the request so they
    // are already registered on the first ACCESS cycle.
    assign w_mem_we     = !we      ? 2'b00 :
                          !byte_op ? 2'b11 :
                          (addr[0] ? 2'b10 : 2'b01);
    assign w_mem_wdata  = byte_op ? {wdata[7:0], wdata[7:0]} : wdata;
    assign w_misaligned = !byte_op && addr[0];

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_we_l      <= 1'b0;
            r_lsb_l     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_unaligned <= 1'b0;
            r_timeout   <= 1'b0;
            r_rdata     <= 16'd0;
            r_rbyte     <= 8'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 2'b00;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_busy  <= 1'b1;
                        r_we_l  <= we;
                        r_lsb_l <= addr[0];
                        if (w_misaligned) begin
                            r_state     <= S_FAULT;
                            r_done      <= 1'b1;
                            r_unaligned <= 1'b1;
                        end else begin
                            r_state     <= S_ACCESS;
                            r_cnt       <= 8'd0;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= w_mem_we;
                            r_mem_addr  <= {addr[15:1], 1'b0};
                            r_mem_wdata <= w_mem_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ready wins over the wait limit on the final allowed cycle.
                    if (mem_r) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 2'b00;
                        if (!r_we_l) begin
                            r_rdata <= mem_rdata;
                            r_rbyte <= r_lsb_l ? mem_rdata[15:8] : mem_rdata[7:0];
                        end
                    end else if (r_cnt == 8'(MAX_WAIT - 1)) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_mem_en  <= 1'b0;
                        r_mem_we  <= 2'b00;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_FAULT, S_DONE: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_unaligned <= 1'b0;
                    r_timeout   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign unaligned = r_unaligned;
    assign timeout   = r_timeout;
    assign rdata     = r_rdata;
    assign rbyte     = r_rbyte;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_byte_unit.sv
// tb/tb_mem_byte_unit.sv - scoreboard bench for mem_byte_unit with randomized accesses
module tb_mem_byte_unit;

    localparam int MAX_WAIT = 15;

    logic        clk_50 = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        byte_op = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [15:0] wdata = 16'd0;
    logic        busy, done, unaligned, timeout;
    logic [15:0] rdata;
    logic [7:0]  rbyte;
    logic        mem_en;
    logic [1:0]  mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_r = 1'b0;

    mem_byte_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_50(clk_50), .reset(reset), .req(req), .we(we), .byte_op(byte_op),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .unaligned(unaligned),
        .timeout(timeout), .rdata(rdata), .rbyte(rbyte), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_r(mem_r)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        logic        fault;
        logic        to;
        logic [15:0] maddr;
        logic [1:0]  mwe;
        logic [15:0] mwdata;
        logic [15:0] rdata;
        logic [7:0]  rbyte;
        int          cyc;
        int          en;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    logic        manual = 1'b1;
    logic [15:0] m_rdata = 16'd0;
    logic [7:0]  m_rbyte = 8'd0;

    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_vec++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req_v, cyc);
        end
    endtask

    // Monitor: compares memory-side outputs while an access is live and pops one
    // expected completion per done pulse.
    always @(negedge clk_50) begin
        if (!manual && !reset) begin
            if (mem_en) begin
                en_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_mem_en", 1, 0);
                end else begin
                    chk("mem_addr", mem_addr, exp_q[0].maddr);
                    chk("mem_we", mem_we, exp_q[0].mwe);
                    chk("mem_wdata", mem_wdata, exp_q[0].mwdata);
                    chk("busy_access", busy, 1);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("unaligned", unaligned, e.fault);
                    chk("timeout", timeout, e.to);
                    chk("rdata", rdata, e.rdata);
                    chk("rbyte", rbyte, e.rbyte);
                    chk("done_cycle", cyc, e.cyc);
                    chk("mem_en_cycles", en_cnt, e.en);
                    chk("busy_done", busy, 1);
                    chk("mem_en_at_done", mem_en, 0);
                    chk("mem_we_at_done", mem_we, 0);
                end
                en_cnt = 0;
            end else if (unaligned || timeout) begin
                chk("flags_without_done", {unaligned, timeout}, 0);
            end
        end
    end

    // Starts in an IDLE cycle (#1 after an edge) and returns #1 after the edge back into IDLE.
    task automatic run(input logic t_we, input logic t_bop, input logic [15:0] t_addr,
                       input logic [15:0] t_wdata, input int waits, input logic [15:0] rd,
                       input logic hold);
        exp_t e;
        int   nacc;
        e.fault  = !t_bop && t_addr[0];
        e.to     = 1'b0;
        e.maddr  = t_addr & 16'hFFFE;
        e.mwe    = !t_we ? 2'b00 : (!t_bop ? 2'b11 : (2'b01 << t_addr[0]));
        e.mwdata = t_bop ? {t_wdata[7:0], t_wdata[7:0]} : t_wdata;
        nacc     = 0;
        if (e.fault) begin
            e.en  = 0;
            e.cyc = cyc + 1;
        end else begin
            e.to  = (waits >= MAX_WAIT);
            nacc  = e.to ? MAX_WAIT : waits + 1;
            e.en  = nacc;
            e.cyc = cyc + nacc + 1;
            if (!t_we && !e.to) begin
                m_rdata = rd;
                m_rbyte = 8'((rd >> (8 * int'(t_addr[0]))) & 16'h00FF);
            end
        end
        e.rdata = m_rdata;
        e.rbyte = m_rbyte;
        exp_q.push_back(e);

        req = 1'b1; we = t_we; byte_op = t_bop; addr = t_addr; wdata = t_wdata;
        mem_r = 1'($urandom); mem_rdata = 16'($urandom);
        @(posedge clk_50); #1;
        if (!hold) req = 1'b0;
        we = 1'($urandom); byte_op = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        if (e.fault) begin
            @(posedge clk_50); #1;
            req = 1'b0;
            return;
        end
        for (int c = 1; c <= nacc; c++) begin
            mem_r = !e.to && (c == nacc);
            mem_rdata = mem_r ? rd : 16'($urandom);
            @(posedge clk_50); #1;
        end
        mem_r = 1'($urandom); mem_rdata = 16'($urandom);
        @(posedge clk_50); #1;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int g = 0; g < n; g++) begin
            mem_r = 1'($urandom); mem_rdata = 16'($urandom);
            @(posedge clk_50); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_50);
        @(negedge clk_50);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rbyte", rbyte, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk_50); #1;
        reset = 1'b0;
        manual = 1'b0;
        idle(1);

        run(1'b0, 1'b1, 16'h3001, 16'h0000, 0, 16'hA55A, 1'b0);
        run(1'b0, 1'b1, 16'h3000, 16'h0000, 3, 16'hA55A, 1'b0);
        run(1'b1, 1'b1, 16'h4003, 16'h12CD, 1, 16'h0000, 1'b0);
        run(1'b0, 1'b0, 16'h5005, 16'h0000, 0, 16'h0000, 1'b0);
        run(1'b0, 1'b0, 16'h6000, 16'h0000, MAX_WAIT, 16'hBEEF, 1'b0);
        run(1'b0, 1'b0, 16'h6002, 16'h0000, MAX_WAIT - 1, 16'hC0DE, 1'b0);
        run(1'b0, 1'b0, 16'h7000, 16'h0000, 2, 16'h1234, 1'b1);
        run(1'b1, 1'b0, 16'h7002, 16'hFACE, 0, 16'h0000, 1'b1);

        // Reset in the middle of an access.
        manual = 1'b1;
        req = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 16'h8000; mem_r = 1'b0;
        @(posedge clk_50); #1;
        req = 1'b0;
        @(posedge clk_50); #1;
        @(negedge clk_50);
        chk("mid_mem_en", mem_en, 1);
        chk("mid_mem_addr", mem_addr, 16'h8000);
        @(posedge clk_50); #1;
        reset = 1'b1;
        @(posedge clk_50); #1;
        reset = 1'b0;
        @(negedge clk_50);
        chk("rst2_busy", busy, 0);
        chk("rst2_mem_en", mem_en, 0);
        chk("rst2_rdata", rdata, 0);
        chk("rst2_rbyte", rbyte, 0);
        chk("rst2_mem_addr", mem_addr, 0);
        m_rdata = 16'd0;
        m_rbyte = 8'd0;
        en_cnt = 0;
        @(posedge clk_50); #1;
        manual = 1'b0;
        run(1'b0, 1'b1, 16'h9001, 16'h0000, 1, 16'h7E81, 1'b0);

        for (int t = 0; t < 80; t++) begin
            int w;
            w = ($urandom_range(0, 5) == 0) ? $urandom_range(MAX_WAIT - 2, MAX_WAIT + 2)
                                            : $urandom_range(0, 3);
            run(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), w,
                16'($urandom), ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
